mm_bridge_loader: RTL and testbench
===================================

MM_BRIDGE_LOADER -- requirements
Module: mm_bridge_loader

Interface
REQ-001 SHALL have parameter s, default 8: number of 17-bit operand sections.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096: watchdog limit, used only with MM_BRIDGE_TIMEOUT_EN.
REQ-003 clock_i  in  1  single clock; all logic on rising edge.
REQ-004 reset_i  in  1  asynchronous, active-high reset.
REQ-005 start_i  in  1  one-cycle request to run one multiplication transaction.
REQ-006 in_data_i  in  17  operand word stream; in_valid_i  in  1; in_ready_o  out  1.
REQ-007 out_data_o  out  17  result word stream; out_valid_o  out  1; out_ready_i  in  1.
REQ-008 BRAM_addr_o  out  32  bridge BRAM port address; BRAM_din_o  out  17; BRAM_dout_i  in  17; BRAM_we_o  out  1; BRAM_en_o  out  1.
REQ-009 MM_start_o  out  1  start pulse to multiplier; MM_done_i  in  1  multiplier completion pulse.
REQ-010 busy_o  out  1  high outside IDLE; done_o  out  1  one-cycle pulse at transaction end; error_o  out  1  sticky timeout flag.

Function
REQ-011 States SHALL be IDLE, LOAD, START, WAIT, RD_REQ, RD_CAP, OUT, FIN.
REQ-012 IDLE: start_i=1 SHALL go to LOAD and clear the word counter and error_o; start_i outside IDLE SHALL be ignored.
REQ-013 LOAD: in_ready_o=1; each in_valid_i&in_ready_o beat SHALL write in_data_i to BRAM same cycle (BRAM_en_o=1, BRAM_we_o=1) at address = counter, counter+1.
REQ-014 Address map SHALL be: 0 p_prime_0; 1..s p; s+1..2s a; 2s+1..3s b; LOAD accepts exactly 3s+1 words, then goes to START.
REQ-015 START SHALL assert MM_start_o for exactly one cycle, then enter WAIT; BRAM_en_o=0 in START and WAIT.
REQ-016 WAIT: MM_done_i=1 SHALL go to RD_REQ with counter reset to 0; MM_done_i in any other state SHALL be ignored.
REQ-017 Result region SHALL be addresses s+1..2s (overwrites a); result word k at address s+1+k.
REQ-018 RD_REQ SHALL drive BRAM_en_o=1, BRAM_we_o=0, address s+1+k for one cycle; RD_CAP SHALL register BRAM_dout_i (one-cycle read latency) into out_data_o and enter OUT.
REQ-019 OUT: out_valid_o=1, out_data_o stable until out_ready_i=1; on acceptance counter+1, then RD_REQ if k<s-1 else FIN.
REQ-020 FIN SHALL pulse done_o one cycle and return to IDLE.
REQ-021 BRAM_addr_o upper bits above $clog2(4*s) SHALL be zero; BRAM_din_o SHALL be 0 when BRAM_we_o=0.
REQ-022 Throughput: load 1 word/cycle when in_valid_i held high; readback minimum 3 cycles/word.

Reset
REQ-023 reset_i=1 at any time, including mid-LOAD or mid-OUT, SHALL immediately force IDLE, counter 0, all outputs 0, out_data_o 0, error_o 0.
REQ-024 Partially loaded BRAM contents after reset SHALL not be cleared; next transaction rewrites all 3s+1 words.

Configuration
REQ-025 Macro MM_BRIDGE_TIMEOUT_EN defined: WAIT SHALL count cycles; at TIMEOUT_CYCLES without MM_done_i, set error_o=1, pulse done_o, return to IDLE without readback.
REQ-026 Macro undefined: no watchdog counter, WAIT lasts indefinitely, error_o tied 0.

Verification (s=8)
REQ-027 Load 25 words 0x00001..0x00019 with in_valid_i constant -> 25 consecutive writes addr 0..24, MM_start_o single pulse on cycle after last write.
REQ-028 Model returns MM_done_i after 100 cycles with BRAM 9..16 = 0x1AAAA.. -> 8 out beats in address order 9..16, then done_o pulse, busy_o low.
REQ-029 out_ready_i low 5 cycles on beat 3 -> out_data_o held constant, no extra BRAM reads, all 8 beats delivered once.
REQ-030 reset_i asserted after 10 load words -> outputs 0 same cycle; new start_i loads from address 0 again.
REQ-031 With MM_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=64, MM_done_i never -> error_o=1 and done_o pulse 64 cycles after WAIT entry; no out_valid_o.
REQ-032 start_i pulsed during WAIT and spurious MM_done_i during LOAD -> both ignored, transaction completes normally.

Source files
------------

// File: rtl/mm_bridge_loader_if.sv
// Stream, BRAM and multiplier-handshake bundle for mm_bridge_loader.
// master: the loader's view; slave: the environment (source, sink, BRAM, multiplier).
interface mm_bridge_loader_if;
   logic [16:0] in_data_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [16:0] out_data_o;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] BRAM_addr_o;
   logic [16:0] BRAM_din_o;
   logic [16:0] BRAM_dout_i;
   logic        BRAM_we_o;
   logic        BRAM_en_o;
   logic        MM_start_o;
   logic        MM_done_i;

   modport master (
      input  in_data_i, in_valid_i, out_ready_i, BRAM_dout_i, MM_done_i,
      output in_ready_o, out_data_o, out_valid_o, BRAM_addr_o, BRAM_din_o,
             BRAM_we_o, BRAM_en_o, MM_start_o
   );

   modport slave (
      output in_data_i, in_valid_i, out_ready_i, BRAM_dout_i, MM_done_i,
      input  in_ready_o, out_data_o, out_valid_o, BRAM_addr_o, BRAM_din_o,
             BRAM_we_o, BRAM_en_o, MM_start_o
   );
endinterface

// File: rtl/mm_bridge_loader.sv
// Loads p_prime_0/p/a/b into the multiplier's bridge BRAM, kicks the multiplier and streams the result back.
// Optional WAIT watchdog enabled by defining MM_BRIDGE_TIMEOUT_EN.
module mm_bridge_loader #(
   parameter int s              = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               start_i,
   mm_bridge_loader_if.master bus,
   output logic               busy_o,
   output logic               done_o,
   output logic               error_o
);
   localparam int AW = $clog2(4 * s);
   localparam logic [AW-1:0] CNT_ONE   = AW'(1);
   localparam logic [AW-1:0] LAST_LOAD = AW'(3 * s);
   localparam logic [AW-1:0] LAST_RD   = AW'(s - 1);
   localparam logic [AW-1:0] RES_BASE  = AW'(s + 1);

   if (s < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("mm_bridge_loader: s and TIMEOUT_CYCLES must be positive");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      START  = 3'd2,
      WAIT   = 3'd3,
      RD_REQ = 3'd4,
      RD_CAP = 3'd5,
      OUT    = 3'd6,
      FIN    = 3'd7
   } state_t;

   state_t        state_r;
   state_t        state_nx_s;
   logic [AW-1:0] cnt_r;
   logic [AW-1:0] cnt_nx_s;
   logic [16:0]   out_data_r;
   logic [AW-1:0] addr_s;
   logic          in_ready_s;
   logic          bram_en_s;
   logic          bram_we_s;
   logic          mm_start_s;
   logic          out_valid_s;
   logic          done_s;
   logic          timeout_s;

`ifdef MM_BRIDGE_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wdog_r;
   logic          error_r;

   // timeout fires on the last WAIT cycle of the budget unless the multiplier answers
   assign timeout_s = (state_r == WAIT) && !bus.MM_done_i &&
                      (wdog_r == WW'(TIMEOUT_CYCLES - 1));

   // WAIT-cycle watchdog and sticky error flag (cleared by the next accepted start)
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         wdog_r  <= {WW{1'b0}};
         error_r <= 1'b0;
      end else begin
         if (state_r == WAIT) begin
            wdog_r <= wdog_r + WW'(1);
         end else begin
            wdog_r <= {WW{1'b0}};
         end
         if (state_r == IDLE && start_i) begin
            error_r <= 1'b0;
         end else if (timeout_s) begin
            error_r <= 1'b1;
         end else begin
            error_r <= error_r;
         end
      end
   end

   assign error_o = error_r;
`else
   assign timeout_s = 1'b0;
   assign error_o   = 1'b0;
`endif

   // state, word counter and the captured result word
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_r    <= IDLE;
         cnt_r      <= {AW{1'b0}};
         out_data_r <= 17'd0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         if (state_r == RD_CAP) begin
            out_data_r <= bus.BRAM_dout_i;
         end else begin
            out_data_r <= out_data_r;
         end
      end
   end

   // next-state, counter and handshake/BRAM controls
   always_comb begin
      state_nx_s  = state_r;
      cnt_nx_s    = cnt_r;
      in_ready_s  = 1'b0;
      bram_en_s   = 1'b0;
      bram_we_s   = 1'b0;
      addr_s      = {AW{1'b0}};
      mm_start_s  = 1'b0;
      out_valid_s = 1'b0;
      done_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_i) begin
               state_nx_s = LOAD;
               cnt_nx_s   = {AW{1'b0}};
            end else begin
               state_nx_s = IDLE;
            end
         end
         LOAD: begin
            in_ready_s = 1'b1;
            addr_s     = cnt_r;
            if (bus.in_valid_i) begin
               bram_en_s = 1'b1;
               bram_we_s = 1'b1;
               cnt_nx_s  = cnt_r + CNT_ONE;
               if (cnt_r == LAST_LOAD) begin
                  state_nx_s = START;
               end else begin
                  state_nx_s = LOAD;
               end
            end else begin
               state_nx_s = LOAD;
            end
         end
         START: begin
            mm_start_s = 1'b1;
            state_nx_s = WAIT;
         end
         WAIT: begin
            if (bus.MM_done_i) begin
               state_nx_s = RD_REQ;
               cnt_nx_s   = {AW{1'b0}};
            end else if (timeout_s) begin
               state_nx_s = FIN;
            end else begin
               state_nx_s = WAIT;
            end
         end
         RD_REQ: begin
            bram_en_s  = 1'b1;
            addr_s     = RES_BASE + cnt_r;
            state_nx_s = RD_CAP;
         end
         RD_CAP: begin
            state_nx_s = OUT;
         end
         OUT: begin
            out_valid_s = 1'b1;
            if (bus.out_ready_i) begin
               cnt_nx_s = cnt_r + CNT_ONE;
               if (cnt_r == LAST_RD) begin
                  state_nx_s = FIN;
               end else begin
                  state_nx_s = RD_REQ;
               end
            end else begin
               state_nx_s = OUT;
            end
         end
         FIN: begin
            done_s     = 1'b1;
            state_nx_s = IDLE;
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   assign bus.in_ready_o  = in_ready_s;
   assign bus.out_valid_o = out_valid_s;
   assign bus.out_data_o  = out_data_r;
   assign bus.BRAM_en_o   = bram_en_s;
   assign bus.BRAM_we_o   = bram_we_s;
   assign bus.BRAM_addr_o = {{(32 - AW){1'b0}}, addr_s};
   assign bus.BRAM_din_o  = bram_we_s ? bus.in_data_i : 17'd0;
   assign bus.MM_start_o  = mm_start_s;
   assign busy_o          = (state_r != IDLE);
   assign done_o          = done_s;
endmodule

// File: tb/tb_mm_bridge_loader.sv
// Directed bench for mm_bridge_loader: table-driven load/readback plus reset, stall and spurious-input sequences.
// BRAM and multiplier are modelled here; result words are written by the multiplier model.
module tb_mm_bridge_loader;
   localparam int S   = 8;
   localparam int NW  = 3 * S + 1;
   localparam int TMO = 64;

   typedef struct {
      logic [16:0] data;
      logic        mm_done;
      logic [31:0] addr;
   } load_vec_t;

   typedef struct {
      logic [16:0] exp;
      int          stall;
   } rd_vec_t;

   logic clock_i = 1'b0;
   logic reset_i;
   logic start_i;
   logic busy_o;
   logic done_o;
   logic error_o;

   mm_bridge_loader_if bus ();

   mm_bridge_loader #(.s(S), .TIMEOUT_CYCLES(TMO)) dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .start_i (start_i),
      .bus     (bus),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .error_o (error_o)
   );

   always #5 clock_i = ~clock_i;

   load_vec_t   load_tbl [NW];
   rd_vec_t     rd_tbl [S];
   logic [16:0] res_vals [S];
   logic [16:0] mem [64];
   logic        mm_load;
   int          n_rd = 0;
   int          n_outval = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   // BRAM with one-cycle read latency; the multiplier model drops its result words in on mm_load
   always @(posedge clock_i) begin
      if (mm_load) begin
         for (int k = 0; k < S; k++) mem[S + 1 + k] <= res_vals[k];
      end
      if (bus.BRAM_en_o && bus.BRAM_we_o) mem[bus.BRAM_addr_o[5:0]] <= bus.BRAM_din_o;
      if (bus.BRAM_en_o && !bus.BRAM_we_o) begin
         bus.BRAM_dout_i <= mem[bus.BRAM_addr_o[5:0]];
         n_rd <= n_rd + 1;
      end
      if (bus.out_valid_o) n_outval <= n_outval + 1;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // called on a negedge with the DUT idle; returns in LOAD
   task automatic run_start();
      start_i = 1'b1;
      #1;
      check("idle_busy", 32'(busy_o), 32'd0);
      @(negedge clock_i);
      start_i = 1'b0;
      #1;
      check("load_entry", {30'd0, busy_o, bus.in_ready_o}, 32'd3);
   endtask

   task automatic load_words(input int n);
      for (int i = 0; i < n; i++) begin
         bus.in_valid_i = 1'b1;
         bus.in_data_i  = load_tbl[i].data;
         bus.MM_done_i  = load_tbl[i].mm_done;
         #1;
         check("load_ready", 32'(bus.in_ready_o), 32'd1);
         check("load_en_we", {30'd0, bus.BRAM_en_o, bus.BRAM_we_o}, 32'd3);
         check("load_addr", bus.BRAM_addr_o, load_tbl[i].addr);
         check("load_din", 32'(bus.BRAM_din_o), 32'(load_tbl[i].data));
         check("load_no_mmstart", 32'(bus.MM_start_o), 32'd0);
         @(negedge clock_i);
      end
      bus.in_valid_i = 1'b0;
      bus.MM_done_i  = 1'b0;
   endtask

   // at the negedge in START: check the pulse, then step into WAIT
   task automatic check_start();
      #1;
      check("start_pulse", 32'(bus.MM_start_o), 32'd1);
      check("start_bram_idle", {30'd0, bus.BRAM_en_o, bus.in_ready_o}, 32'd0);
      @(negedge clock_i);
      #1;
      check("wait_entry", {30'd0, busy_o, bus.MM_start_o}, 32'd2);
   endtask

   task automatic finish_mm();
      bus.MM_done_i = 1'b1;
      mm_load       = 1'b1;
      @(negedge clock_i);
      bus.MM_done_i = 1'b0;
      mm_load       = 1'b0;
   endtask

   task automatic read_beats(input int nb);
      for (int k = 0; k < nb; k++) begin
         #1;
         check("rd_req", {29'd0, bus.BRAM_en_o, bus.BRAM_we_o, bus.out_valid_o}, 32'd4);
         check("rd_addr", bus.BRAM_addr_o, 32'(S + 1 + k));
         @(negedge clock_i);
         #1;
         check("rd_cap", {30'd0, bus.BRAM_en_o, bus.out_valid_o}, 32'd0);
         @(negedge clock_i);
         for (int st = 0; st < rd_tbl[k].stall; st++) begin
            bus.out_ready_i = 1'b0;
            #1;
            check("out_hold", {14'd0, bus.out_valid_o, bus.out_data_o}, {15'd1, rd_tbl[k].exp});
            check("out_hold_no_rd", 32'(bus.BRAM_en_o), 32'd0);
            @(negedge clock_i);
         end
         bus.out_ready_i = 1'b1;
         #1;
         check("out_data", {14'd0, bus.out_valid_o, bus.out_data_o}, {15'd1, rd_tbl[k].exp});
         @(negedge clock_i);
         bus.out_ready_i = 1'b0;
      end
   endtask

   initial begin
      int rd0;
      int ov0;
      int c;
      reset_i         = 1'b1;
      start_i         = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.in_data_i   = 17'd0;
      bus.out_ready_i = 1'b0;
      bus.MM_done_i   = 1'b0;
      mm_load         = 1'b0;
      for (int i = 0; i < NW; i++) begin
         load_tbl[i].data    = 17'(i + 1);
         load_tbl[i].mm_done = (i == 5);
         load_tbl[i].addr    = 32'(i);
      end
      for (int k = 0; k < S; k++) begin
         res_vals[k]     = 17'h1AAAA + 17'(k);
         rd_tbl[k].exp   = 17'h1AAAA + 17'(k);
         rd_tbl[k].stall = (k == 3) ? 5 : 0;
      end

      repeat (2) @(negedge clock_i);
      #1;
      check("rst_busy_done_err", {29'd0, busy_o, done_o, error_o}, 32'd0);
      check("rst_ready_valid", {30'd0, bus.in_ready_o, bus.out_valid_o}, 32'd0);
      check("rst_out_data", 32'(bus.out_data_o), 32'd0);
      check("rst_bram", {bus.BRAM_addr_o[29:0], bus.BRAM_en_o, bus.BRAM_we_o}, 32'd0);
      check("rst_mmstart", 32'(bus.MM_start_o), 32'd0);
      @(negedge clock_i);
      reset_i = 1'b0;

      // full transaction: spurious MM_done in LOAD, start in WAIT, stall on beat 3
      @(negedge clock_i);
      run_start();
      load_words(NW);
      for (int i = 0; i < NW; i++) check("mem_loaded", 32'(mem[i]), 32'(i + 1));
      check_start();
      for (int w = 0; w < 98; w++) begin
         start_i = (w == 40);
         #1;
         check("wait_quiet", {28'd0, busy_o, bus.MM_start_o, bus.BRAM_en_o, bus.out_valid_o}, 32'd8);
         @(negedge clock_i);
      end
      start_i = 1'b0;
      rd0 = n_rd;
      finish_mm();
      read_beats(S);
      #1;
      check("fin_done", {29'd0, busy_o, done_o, bus.out_valid_o}, 32'd6);
      check("read_count", 32'(n_rd - rd0), 32'(S));
      @(negedge clock_i);
      #1;
      check("after_fin", {29'd0, busy_o, done_o, error_o}, 32'd0);

      // reset during LOAD, then reload from address 0
      @(negedge clock_i);
      run_start();
      load_words(10);
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = 17'h0ABCD;
      reset_i        = 1'b1;
      #1;
      check("rst_load_ctrl", {28'd0, busy_o, bus.in_ready_o, bus.BRAM_en_o, bus.BRAM_we_o}, 32'd0);
      check("rst_load_addr_din", {bus.BRAM_addr_o[14:0], bus.BRAM_din_o}, 32'd0);
      @(negedge clock_i);
      reset_i        = 1'b0;
      bus.in_valid_i = 1'b0;
      @(negedge clock_i);
      run_start();
      load_words(NW);
      check_start();
      repeat (5) @(negedge clock_i);
      finish_mm();
      read_beats(1);
      repeat (2) @(negedge clock_i);
      #1;
      check("out_beat1", {14'd0, bus.out_valid_o, bus.out_data_o}, {15'd1, rd_tbl[1].exp});
      reset_i = 1'b1;
      #1;
      check("rst_out", {14'd0, bus.out_valid_o, bus.out_data_o}, 32'd0);
      check("rst_out_busy", 32'(busy_o), 32'd0);
      @(negedge clock_i);
      reset_i = 1'b0;

      // multiplier never answers
      @(negedge clock_i);
      run_start();
      load_words(NW);
      check_start();
      ov0 = n_outval;
      c   = 0;
      while (!done_o && c < 200) begin
         @(negedge clock_i);
         #1;
         c++;
      end
`ifdef MM_BRIDGE_TIMEOUT_EN
      check("timeout_cycles", 32'(c), 32'(TMO));
      check("timeout_error", {30'd0, done_o, error_o}, 32'd3);
      check("timeout_no_out", 32'(n_outval - ov0), 32'd0);
      @(negedge clock_i);
      #1;
      check("timeout_sticky", {30'd0, busy_o, error_o}, 32'd1);
      run_start();
      check("start_clears_err", 32'(error_o), 32'd0);
`else
      check("no_timeout", 32'(c), 32'd200);
      check("no_timeout_state", {29'd0, busy_o, done_o, error_o}, 32'd4);
      check("no_timeout_no_out", 32'(n_outval - ov0), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: got no end of test, expected finish before 200000");
      $fatal(1, "simulation time limit reached");
   end
endmodule
